// File: rtl/mul_arbiter.sv
// Two-requester round-robin arbiter sequencing an external shift-free add/decrement multiplier datapath.
// Optional build macro MUL_ARB_ZERO_SKIP_EN: zero operands bypass the datapath and complete immediately.
module mul_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic [1:0]       done,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic [WIDTH-1:0] dp_data,
   output logic             lda,
   output logic             ldb,
   output logic             ldp,
   output logic             clrp,
   output logic             decb,
   input  logic             eqz,
   input  logic [WIDTH-1:0] p_data
);

   // state | meaning
   // IDLE  | waiting for a request, arbitration happens here
   // LOADA | multiplicand driven onto dp_data with lda
   // LOADB | multiplier driven onto dp_data with ldb, P cleared
   // ACCUM | P += A while B counter is nonzero
   // DONE  | product captured, done pulse to the granted requester
   typedef enum logic [2:0] {IDLE, LOADA, LOADB, ACCUM, DONE} state_t;

   state_t           state;
   logic             ptr;
   logic             gnt;
   logic [WIDTH-1:0] b_lat;
   logic             win;
   logic [WIDTH-1:0] win_a;
   logic [WIDTH-1:0] win_b;
   logic             skip;

   always_comb begin
      win   = (req == 2'b11) ? ptr : req[1];
      win_a = win ? a1 : a0;
      win_b = win ? b1 : b0;
`ifdef MUL_ARB_ZERO_SKIP_EN
      skip  = (win_a == '0) || (win_b == '0);
`else
      skip  = 1'b0;
`endif
   end

   assign ldp  = (state == ACCUM) && !eqz;
   assign decb = ldp;

   // The multiplicand is latched straight into the dp_data register at grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= 1'b0;
         gnt     <= 1'b0;
         b_lat   <= '0;
         result  <= '0;
         done    <= 2'b00;
         busy    <= 1'b0;
         dp_data <= '0;
         lda     <= 1'b0;
         ldb     <= 1'b0;
         clrp    <= 1'b0;
      end else begin
         done    <= 2'b00;
         dp_data <= '0;
         lda     <= 1'b0;
         ldb     <= 1'b0;
         clrp    <= 1'b0;
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  gnt   <= win;
                  b_lat <= win_b;
                  busy  <= 1'b1;
                  if (skip) begin
                     state  <= DONE;
                     done   <= win ? 2'b10 : 2'b01;
                     result <= '0;
                     ptr    <= ~win;
                  end else begin
                     state   <= LOADA;
                     lda     <= 1'b1;
                     dp_data <= win_a;
                  end
               end
            end
            LOADA: begin
               state   <= LOADB;
               ldb     <= 1'b1;
               clrp    <= 1'b1;
               dp_data <= b_lat;
            end
            LOADB: state <= ACCUM;
            ACCUM: begin
               if (eqz) begin
                  state  <= DONE;
                  done   <= gnt ? 2'b10 : 2'b01;
                  result <= p_data;
                  ptr    <= ~gnt;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
